// File: rtl/ksa_mp_seq_pkg.sv
// ksa_seq_pkg: shared definitions for the multi-precision add/subtract sequencer.
//   LIMB_W  - width of one limb and of the shared adder (16 bits)
//   state_t - sequencer states: IDLE=0, PASS_A=1, PASS_B=2, DONE=3
package ksa_seq_pkg;

    localparam int LIMB_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PASS_A = 2'd1,
        PASS_B = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/ksa_mp_seq_if.sv
// ksa_mp_seq_if: request/response bundle of the multi-precision sequencer.
//   in_valid/in_ready/in_sub/in_a/in_b        - operand request handshake
//   out_valid/out_ready/out_sum/out_cout/out_ovf - result handshake and flags
//   busy                                       - sequencer not idle
// Modports: master = requester side, slave = sequencer side.
interface ksa_mp_seq_if #(
    parameter int LIMBS = 4
);
    import ksa_seq_pkg::*;

    localparam int W = LIMB_W * LIMBS;

    logic         in_valid;
    logic         in_ready;
    logic         in_sub;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;
    logic         busy;

    modport master (
        output in_valid, in_sub, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf, busy
    );

    modport slave (
        input  in_valid, in_sub, in_a, in_b, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf, busy
    );

endinterface

// File: rtl/ksa_mp_seq_ksa16.sv
// KSA16: 16-bit Kogge-Stone adder, no carry-in, purely combinational.
//   a, b - addends
//   sum  - a + b modulo 2^16
//   cout - carry out of bit 15
module KSA16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] sum,
    output logic        cout
);

    // Row 0 holds bitwise generate/propagate; row k spans groups of 2^k bits.
    logic [4:0][15:0] g;
    logic [4:0][15:0] p;

    always_comb begin
        g      = '0;
        p      = '0;
        g[0]   = a & b;
        p[0]   = a ^ b;
        for (int lvl = 1; lvl < 5; lvl++) begin
            for (int i = 0; i < 16; i++) begin
                if (i >= (1 << (lvl - 1))) begin
                    g[lvl][i] = g[lvl-1][i] | (p[lvl-1][i] & g[lvl-1][i - (1 << (lvl - 1))]);
                    p[lvl][i] = p[lvl-1][i] & p[lvl-1][i - (1 << (lvl - 1))];
                end else begin
                    g[lvl][i] = g[lvl-1][i];
                    p[lvl][i] = p[lvl-1][i];
                end
            end
        end
        // Bit i sees the carry generated by prefix [i-1:0]; no carry-in at bit 0.
        sum[0] = p[0][0];
        for (int i = 1; i < 16; i++) begin
            sum[i] = p[0][i] ^ g[4][i-1];
        end
        cout = g[4][15];
    end

endmodule

// File: rtl/ksa_mp_seq.sv
// ksa_mp_seq: LIMBS x 16-bit add/subtract built around one shared KSA16.
// Each limb takes two adder passes, LSB limb first: the operand pass adds
// the A and B' limbs, the carry pass adds the running carry into that sum.
// Fixed latency of 2*LIMBS edges from accept to out_valid.
//   wb_clk_i - clock, rising edge
//   wb_rst_i - synchronous active-high reset
//   bus      - slave side of ksa_mp_seq_if (request, result, flags, busy)
module ksa_mp_seq
    import ksa_seq_pkg::*;
#(
    parameter int LIMBS = 4
) (
    input logic          wb_clk_i,
    input logic          wb_rst_i,
    ksa_mp_seq_if.slave  bus
);

    localparam int W = LIMB_W * LIMBS;

    state_t                        state_q, state_d;
    logic [2:0]                    li_q, li_d;
    logic                          cy_q, cy_d;
    logic                          c1_q, c1_d;
    logic [LIMB_W-1:0]             s1_q, s1_d;
    logic [LIMBS-1:0][LIMB_W-1:0]  a_q, a_d;
    logic [LIMBS-1:0][LIMB_W-1:0]  b_q, b_d;
    logic [LIMBS-1:0][LIMB_W-1:0]  res_q, res_d;

    logic [LIMB_W-1:0]             lim_a, lim_b;
    logic [LIMB_W-1:0]             add_a, add_b, add_sum;
    logic                          add_cout;

    KSA16 u_add (
        .a    (add_a),
        .b    (add_b),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        state_d = state_q;
        li_d    = li_q;
        cy_d    = cy_q;
        c1_d    = c1_q;
        s1_d    = s1_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        add_a   = '0;
        add_b   = '0;
        lim_a   = '0;
        lim_b   = '0;

        for (int i = 0; i < LIMBS; i++) begin
            if (li_q == 3'(i)) begin
                lim_a = a_q[i];
                lim_b = b_q[i];
            end
        end

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    // Subtract is a + ~b + 1: invert B now, seed the carry with 1.
                    a_d     = bus.in_a;
                    b_d     = bus.in_b ^ {W{bus.in_sub}};
                    cy_d    = bus.in_sub;
                    li_d    = '0;
                    state_d = PASS_A;
                end
            end
            PASS_A: begin
                add_a   = lim_a;
                add_b   = lim_b;
                s1_d    = add_sum;
                c1_d    = add_cout;
                state_d = PASS_B;
            end
            PASS_B: begin
                add_a = s1_q;
                add_b = {{(LIMB_W-1){1'b0}}, cy_q};
                for (int i = 0; i < LIMBS; i++) begin
                    if (li_q == 3'(i)) begin
                        res_d[i] = add_sum;
                    end
                end
                // Adding a single carry bit can only carry out if s1 was all ones,
                // in which case the operand pass could not have carried.
                cy_d = c1_q | add_cout;
                if (li_q == 3'(LIMBS - 1)) begin
                    state_d = DONE;
                end else begin
                    li_d    = li_q + 3'd1;
                    state_d = PASS_A;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            li_q    <= '0;
            cy_q    <= 1'b0;
            c1_q    <= 1'b0;
            s1_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            li_q    <= li_d;
            cy_q    <= cy_d;
            c1_q    <= c1_d;
            s1_q    <= s1_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_sum   = res_q;
    assign bus.out_cout  = cy_q;
    // Signed overflow: A and B' agree in sign but the result does not.
    assign bus.out_ovf   = (a_q[LIMBS-1][LIMB_W-1] == b_q[LIMBS-1][LIMB_W-1]) &
                           (res_q[LIMBS-1][LIMB_W-1] != a_q[LIMBS-1][LIMB_W-1]);

endmodule

// File: tb/tb_ksa_mp_seq.sv
// tb_ksa_mp_seq: self-checking bench for ksa_mp_seq with LIMBS=4.
module tb_ksa_mp_seq;

    localparam int LIMBS = 4;
    localparam int W     = 64;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    ksa_mp_seq_if #(.LIMBS(LIMBS)) bus ();

    ksa_mp_seq #(.LIMBS(LIMBS)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus)
    );

    // Reference: exact signed result in 65 bits; unsigned compare gives borrow.
    function automatic res_t ref_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        res_t              r;
        logic signed [W:0] ex;
        logic [W:0]        u;
        if (sub) begin
            ex     = $signed({a[W-1], a}) - $signed({b[W-1], b});
            r.cout = (a >= b);
        end else begin
            ex     = $signed({a[W-1], a}) + $signed({b[W-1], b});
            u      = {1'b0, a} + {1'b0, b};
            r.cout = u[W];
        end
        r.sum = ex[W-1:0];
        r.ovf = (ex[W] != ex[W-1]);
        return r;
    endfunction

    // Waits (bounded) for in_ready, presents one request for one edge, then
    // scrambles the inputs. Returns at the negedge right after the accept edge.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub, output bit ok);
        int k = 0;
        while (!bus.in_ready && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (!bus.in_ready) begin
            ok = 1'b0;
            return;
        end
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_sub   = sub;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_a     = {$urandom, $urandom};
        bus.in_b     = {$urandom, $urandom};
        bus.in_sub   = 1'($urandom);
        ok = 1'b1;
    endtask

    // Counts edges from the accept edge until out_valid (bounded) and samples the result.
    task automatic collect(output int lat, output res_t r);
        int k = 0;
        while (!bus.out_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        lat    = k;
        r.sum  = bus.out_sum;
        r.cout = bus.out_cout;
        r.ovf  = bus.out_ovf;
    endtask

    task automatic release_result();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.in_sub    = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_tests++; if (bus.in_ready !== 1'b1)  begin n_fail++; $display("FAIL reset.in_ready got %b exp 1", bus.in_ready); end
        n_tests++; if (bus.busy !== 1'b0)      begin n_fail++; $display("FAIL reset.busy got %b exp 0", bus.busy); end
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset.out_valid got %b exp 0", bus.out_valid); end
        n_tests++; if (bus.out_sum !== 64'h0)  begin n_fail++; $display("FAIL reset.out_sum got %h exp 0", bus.out_sum); end
        n_tests++; if (bus.out_cout !== 1'b0)  begin n_fail++; $display("FAIL reset.out_cout got %b exp 0", bus.out_cout); end
        n_tests++; if (bus.out_ovf !== 1'b0)   begin n_fail++; $display("FAIL reset.out_ovf got %b exp 0", bus.out_ovf); end
    endtask

    task automatic test_add_sub();
        logic [W-1:0] ta [4];
        logic [W-1:0] tb [4];
        logic         ts [4];
        logic [W-1:0] es [4];
        logic         ec [4];
        logic         eo [4];
        bit           ok;
        int           lat;
        res_t         r;
        ta[0] = 64'h0000_0000_0000_FFFF; tb[0] = 64'h1; ts[0] = 1'b0;
        es[0] = 64'h0000_0000_0001_0000; ec[0] = 1'b0; eo[0] = 1'b0;
        ta[1] = 64'hFFFF_FFFF_FFFF_FFFF; tb[1] = 64'h1; ts[1] = 1'b0;
        es[1] = 64'h0;                   ec[1] = 1'b1; eo[1] = 1'b0;
        ta[2] = 64'h5;                   tb[2] = 64'h6; ts[2] = 1'b1;
        es[2] = 64'hFFFF_FFFF_FFFF_FFFF; ec[2] = 1'b0; eo[2] = 1'b0;
        ta[3] = 64'h8000_0000_0000_0000; tb[3] = 64'h1; ts[3] = 1'b1;
        es[3] = 64'h7FFF_FFFF_FFFF_FFFF; ec[3] = 1'b1; eo[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            start_op(ta[i], tb[i], ts[i], ok);
            n_tests++; if (!ok) begin n_fail++; $display("FAIL dir[%0d].accept got timeout exp in_ready", i); continue; end
            collect(lat, r);
            n_tests++; if (lat != 8)       begin n_fail++; $display("FAIL dir[%0d].latency got %0d exp 8", i, lat); end
            n_tests++; if (r.sum !== es[i])  begin n_fail++; $display("FAIL dir[%0d].sum got %h exp %h", i, r.sum, es[i]); end
            n_tests++; if (r.cout !== ec[i]) begin n_fail++; $display("FAIL dir[%0d].cout got %b exp %b", i, r.cout, ec[i]); end
            n_tests++; if (r.ovf !== eo[i])  begin n_fail++; $display("FAIL dir[%0d].ovf got %b exp %b", i, r.ovf, eo[i]); end
            release_result();
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b;
        logic         sub;
        bit           ok;
        int           lat;
        res_t         r, e;
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 3))
                0: begin a = {$urandom, $urandom}; b = {$urandom, $urandom}; end
                1: begin a = ~64'(16'($urandom)); b = 64'(16'($urandom)); end
                2: begin a = 64'(16'($urandom)); b = 64'(16'($urandom)); end
                default: begin a = {1'b1, 63'($urandom)}; b = {1'($urandom), 63'($urandom)}; end
            endcase
            sub = 1'($urandom);
            e   = ref_op(a, b, sub);
            start_op(a, b, sub, ok);
            n_tests++; if (!ok) begin n_fail++; $display("FAIL rnd[%0d].accept got timeout exp in_ready", i); continue; end
            collect(lat, r);
            n_tests++; if (lat != 8)       begin n_fail++; $display("FAIL rnd[%0d].latency got %0d exp 8", i, lat); end
            n_tests++; if (r.sum !== e.sum)   begin n_fail++; $display("FAIL rnd[%0d].sum a=%h b=%h sub=%b got %h exp %h", i, a, b, sub, r.sum, e.sum); end
            n_tests++; if (r.cout !== e.cout) begin n_fail++; $display("FAIL rnd[%0d].cout got %b exp %b", i, r.cout, e.cout); end
            n_tests++; if (r.ovf !== e.ovf)   begin n_fail++; $display("FAIL rnd[%0d].ovf got %b exp %b", i, r.ovf, e.ovf); end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            release_result();
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] a1, b1, a2, b2;
        bit           ok;
        int           lat;
        res_t         r, e1, e2;
        a1 = {$urandom, $urandom}; b1 = {$urandom, $urandom};
        a2 = {$urandom, $urandom}; b2 = {$urandom, $urandom};
        e1 = ref_op(a1, b1, 1'b0);
        e2 = ref_op(a2, b2, 1'b1);
        start_op(a1, b1, 1'b0, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL bp.accept got timeout exp in_ready"); return; end
        collect(lat, r);
        n_tests++; if (lat != 8) begin n_fail++; $display("FAIL bp.latency got %0d exp 8", lat); end
        bus.in_a     = a2;
        bus.in_b     = b2;
        bus.in_sub   = 1'b1;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            n_tests++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp.hold[%0d].out_valid got %b exp 1", c, bus.out_valid); end
            n_tests++; if (bus.out_sum !== e1.sum)  begin n_fail++; $display("FAIL bp.hold[%0d].sum got %h exp %h", c, bus.out_sum, e1.sum); end
            n_tests++; if (bus.out_cout !== e1.cout || bus.out_ovf !== e1.ovf)
                begin n_fail++; $display("FAIL bp.hold[%0d].flags got %b%b exp %b%b", c, bus.out_cout, bus.out_ovf, e1.cout, e1.ovf); end
            n_tests++; if (bus.in_ready !== 1'b0)   begin n_fail++; $display("FAIL bp.hold[%0d].in_ready got %b exp 0", c, bus.in_ready); end
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp.idle.in_ready got %b exp 1", bus.in_ready); end
        @(negedge clk);
        bus.in_valid = 1'b0;
        n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL bp.accept2.busy got %b exp 1", bus.busy); end
        collect(lat, r);
        n_tests++; if (lat != 8)         begin n_fail++; $display("FAIL bp.latency2 got %0d exp 8", lat); end
        n_tests++; if (r.sum !== e2.sum) begin n_fail++; $display("FAIL bp.sum2 got %h exp %h", r.sum, e2.sum); end
        n_tests++; if (r.cout !== e2.cout || r.ovf !== e2.ovf)
            begin n_fail++; $display("FAIL bp.flags2 got %b%b exp %b%b", r.cout, r.ovf, e2.cout, e2.ovf); end
        release_result();
    endtask

    task automatic test_mid_reset();
        bit   ok;
        bit   seen;
        int   lat;
        res_t r;
        start_op({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL mrst.accept got timeout exp in_ready"); return; end
        repeat (4) @(negedge clk);
        n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL mrst.busy got %b exp 1", bus.busy); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_tests++; if (bus.in_ready !== 1'b1)  begin n_fail++; $display("FAIL mrst.in_ready got %b exp 1", bus.in_ready); end
        n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mrst.out_valid got %b exp 0", bus.out_valid); end
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        n_tests++; if (seen) begin n_fail++; $display("FAIL mrst.no_pulse got 1 exp 0"); end
        start_op(64'h1234, 64'h4321, 1'b0, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL mrst.accept2 got timeout exp in_ready"); return; end
        collect(lat, r);
        n_tests++; if (lat != 8)             begin n_fail++; $display("FAIL mrst.latency got %0d exp 8", lat); end
        n_tests++; if (r.sum !== 64'h5555)   begin n_fail++; $display("FAIL mrst.sum got %h exp 5555", r.sum); end
        n_tests++; if (r.cout !== 1'b0)      begin n_fail++; $display("FAIL mrst.cout got %b exp 0", r.cout); end
        release_result();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a, b;
        res_t         e;
        int           t [2];
        int           nv;
        int           k;
        a  = {$urandom, $urandom};
        b  = {$urandom, $urandom};
        e  = ref_op(a, b, 1'b0);
        nv = 0;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_sub    = 1'b0;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 40 && nv < 2; c++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                t[nv] = c;
                n_tests++; if (bus.out_sum !== e.sum) begin n_fail++; $display("FAIL b2b[%0d].sum got %h exp %h", nv, bus.out_sum, e.sum); end
                nv++;
            end
        end
        bus.in_valid = 1'b0;
        n_tests++;
        if (nv != 2) begin
            n_fail++; $display("FAIL b2b.results got %0d exp 2", nv);
        end else if (t[1] - t[0] != 10) begin
            n_fail++; $display("FAIL b2b.period got %0d exp 10", t[1] - t[0]);
        end
        k = 0;
        while (!bus.in_ready && k < 40) begin
            @(negedge clk);
            k++;
        end
        bus.out_ready = 1'b0;
        n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b.drain got %b exp 1", bus.in_ready); end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_random();
        test_backpressure();
        test_mid_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ksa_mp_seq.md
# ksa_mp_seq

Multi-precision add/subtract sequencer that time-multiplexes a single 16-bit Kogge-Stone adder (KSA16, no carry-in) to compute LIMBS×16-bit results. It accepts operands through a valid/ready handshake, walks the limbs LSB-first with two adder passes per limb (operand pass, then carry-inject pass), and presents a registered result with carry and signed-overflow flags. It sits between the Wishbone-facing user-project logic and the adder instance.

## Interface
- LIMBS, default 4: number of 16-bit limbs; W = 16*LIMBS; legal range 1..8.
- wb_clk_i  in  1  sole clock, rising edge.
- wb_rst_i  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept; high only in IDLE.
- in_sub  in  1  0 = a+b, 1 = a−b.
- in_a  in  W  operand A.
- in_b  in  W  operand B.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_sum  out  W  result.
- out_cout  out  1  final carry; for subtract, 1 = no borrow.
- out_ovf  out  1  two's-complement overflow.
- busy  out  1  high in any state except IDLE.

## Operation
- States: IDLE, PASS_A, PASS_B, DONE. Limb index `li` (3 bits), carry register `cy`.
- IDLE: in_ready=1. Accept on in_valid&in_ready: capture a, b^{W{sub}} and sub into internal registers; set cy=sub, li=0; go to PASS_A. Inputs may change after the accept edge.
- PASS_A: adder inputs = a[li], b'[li]; register s1 = sum and c1 = cout; go to PASS_B.
- PASS_B: adder inputs = s1, {15'b0, cy}; write sum into result limb li; cy ← c1|c2 (the two cannot both be 1). If li==LIMBS−1, go to DONE; otherwise li+1 and go to PASS_A.
- DONE: out_valid=1. out_cout=cy. out_ovf = (a_msb==b'_msb) & (sum_msb!=a_msb), where b' is the inverted B for subtract. On out_ready, go to IDLE.
- The adder is instantiated once. Its inputs are muxed by state. IDLE/DONE drive zeros.
- Reset: state IDLE, li=0, cy=0. All operand and result registers clear to 0. Outputs after reset: in_ready=1, out_valid=0, out_sum=0, out_cout=0, out_ovf=0, busy=0.
- Reset mid-operation: the operation is abandoned and no out_valid pulse occurs.

## Timing
- Fixed latency: out_valid rises exactly 2*LIMBS clock edges after the accept edge (8 for LIMBS=4). It is independent of the data, and the carry pass is never skipped.
- Throughput: one operation per 2*LIMBS+2 cycles with out_ready held high. DONE→IDLE takes one edge, and the next accept happens in IDLE.
- While out_valid & !out_ready, out_sum, out_cout and out_ovf stay stable.
- in_ready is 0 from the accept edge until IDLE is re-entered. in_valid during busy is ignored.
- All outputs are registered or decoded from state only. There is no combinational path from in_* or out_ready to any output.

## Structure
- Shared package ksa_seq_pkg holds the state encodings (IDLE=0, PASS_A=1, PASS_B=2, DONE=3) and LIMB_W=16.
- There is exactly one sub-module instance: KSA16 (u_add). The limb mux, FSM and flag logic stay inline.

## Test plan
All scenarios use LIMBS=4.
- Reset: hold wb_rst_i for 2 cycles → in_ready=1, busy=0, out_valid=0, out_sum=0 on the first post-reset cycle.
- Add, carry across limbs: 0x0000_0000_0000_FFFF + 0x1 → out_sum=0x0000_0000_0001_0000, cout=0, ovf=0. out_valid is asserted exactly 8 edges after the accept edge.
- Add, full wrap: 0xFFFF_FFFF_FFFF_FFFF + 0x1 → out_sum=0, cout=1, ovf=0.
- Subtract:
  - 5 − 6 → out_sum=0xFFFF_FFFF_FFFF_FFFF, cout=0, ovf=0.
  - 0x8000_0000_0000_0000 − 1 → out_sum=0x7FFF_FFFF_FFFF_FFFF, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands → result and flags stay stable and in_ready=0. After out_ready=1, the new operands are accepted one cycle later.
- Mid-operation reset: assert wb_rst_i for 1 cycle during PASS_A of limb 2 → no out_valid pulse, and in_ready=1 on the following cycle. A subsequent 0x1234 + 0x4321 returns 0x5555 with cout=0.
